// File: rtl/dma_pkg.sv
// Shared DMA definitions: register map, DMA status codes,
// completion codes and the transfer descriptor bundle.
package dma_pkg;

    localparam logic [31:0] REG_READ_SOURCE  = 32'h00;
    localparam logic [31:0] REG_WRITE_DEST   = 32'h04;
    localparam logic [31:0] REG_BURST_SIZE   = 32'h08;
    localparam logic [31:0] REG_START        = 32'h0C;
    localparam logic [31:0] REG_WRITE_STATUS = 32'h10;
    localparam logic [31:0] REG_READ_STATUS  = 32'h14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } dma_st_e;

    typedef enum logic [1:0] {
        CMP_OK      = 2'b00,
        CMP_BUS_ERR = 2'b01,
        CMP_DMA_ERR = 2'b10,
        CMP_TIMEOUT = 2'b11
    } cmp_st_e;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [11:0] len;
    } desc_t;

endpackage

// File: rtl/dma_desc_sequencer_if.sv
// Register-port bundle between the descriptor sequencer (master)
// and the DMA register block (slave).
//   paddr/pwdata : address and write data, held until perr[0]
//   pwenable     : one-cycle write request
//   prenable     : one-cycle read request
//   prdata       : read data, valid with perr[0]
//   perr         : [0] access complete, [1] bad address
interface dma_desc_sequencer_if;

    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwenable;
    logic        prenable;
    logic [31:0] prdata;
    logic [1:0]  perr;

    modport master (
        output paddr, pwdata, pwenable, prenable,
        input  prdata, perr
    );

    modport slave (
        input  paddr, pwdata, pwenable, prenable,
        output prdata, perr
    );

endinterface

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO, DEPTH a power of two.
// Ports: clk, rstn (sync, active low), push/wdata in,
//        pop in, rdata (head), full, empty, level out.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  desc_t       wdata,
    input  logic        pop,
    output desc_t       rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    desc_t          mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH by themselves.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dma_desc_sequencer.sv
// Queues DMA descriptors, programs each through the register port,
// polls write status and emits one completion record per descriptor.
// Ports: clk, rstn (sync, active low); desc_valid/desc_ready/
//        desc_src/desc_dst/desc_len descriptor input; bus (register
//        master port); cmp_valid/cmp_status completion; busy;
//        fifo_level.
// Option: define DESC_SEQ_TIMEOUT_EN to bound each register access
//         to TIMEOUT_CYC cycles (completion status 11 on expiry).
module dma_desc_sequencer
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int POLL_GAP    = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        desc_valid,
    output logic                        desc_ready,
    input  logic [31:0]                 desc_src,
    input  logic [31:0]                 desc_dst,
    input  logic [11:0]                 desc_len,
    dma_desc_sequencer_if.master        bus,
    output logic                        cmp_valid,
    output logic [1:0]                  cmp_status,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        POLL_GAP < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dma_desc_sequencer: illegal parameter value");
    end

    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_SRC,
        S_LD_DST,
        S_LD_LEN,
        S_START,
        S_POLL,
        S_GAP,
        S_CMP
    } state_e;

    state_e      state;
    logic [31:0] cur_dst;
    logic [11:0] cur_len;
    logic [31:0] paddr_r;
    logic [31:0] pwdata_r;
    logic        pwen_r;
    logic        pren_r;
    logic        cmp_valid_r;
    cmp_st_e     cmp_status_r;
    logic [GW-1:0] gap_cnt;

    desc_t       in_desc;
    desc_t       head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        in_acc;
    logic        ack;
    logic        acc_expired;
    dma_st_e     poll_st;
    logic        unused_prdata;

    assign in_desc    = '{src: desc_src, dst: desc_dst, len: desc_len};
    assign desc_ready = !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;

    dma_desc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (desc_valid && desc_ready),
        .wdata (in_desc),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign in_acc = (state == S_LD_SRC) || (state == S_LD_DST) ||
                    (state == S_LD_LEN) || (state == S_START)  ||
                    (state == S_POLL);

    // The enable cycle itself never carries a completion.
    assign ack = in_acc && !pwen_r && !pren_r && bus.perr[0];

    assign poll_st       = dma_st_e'(bus.prdata[1:0]);
    assign unused_prdata = ^bus.prdata[31:2];

`ifdef DESC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Holds the number of cycles since the last enable pulse,
    // saturating so a stuck access cannot wrap back to zero.
    logic [TW-1:0] acc_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_cnt <= '0;
        end else if (pwen_r || pren_r) begin
            acc_cnt <= TW'(1);
        end else if (in_acc && acc_cnt != TW'(TIMEOUT_CYC)) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    assign acc_expired = in_acc && !pwen_r && !pren_r &&
                         (acc_cnt == TW'(TIMEOUT_CYC));
`else
    assign acc_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cur_dst      <= '0;
            cur_len      <= '0;
            paddr_r      <= '0;
            pwdata_r     <= '0;
            pwen_r       <= 1'b0;
            pren_r       <= 1'b0;
            cmp_valid_r  <= 1'b0;
            cmp_status_r <= CMP_OK;
            gap_cnt      <= '0;
        end else begin
            pwen_r      <= 1'b0;
            pren_r      <= 1'b0;
            cmp_valid_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur_dst <= head.dst;
                        cur_len <= head.len;
                        if (head.len == '0) begin
                            state        <= S_CMP;
                            cmp_valid_r  <= 1'b1;
                            cmp_status_r <= CMP_OK;
                        end else begin
                            state    <= S_LD_SRC;
                            paddr_r  <= REG_READ_SOURCE;
                            pwdata_r <= head.src;
                            pwen_r   <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= S_POLL;
                        pren_r <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_CMP: begin
                    state <= S_IDLE;
                end
                default: begin
                    if (ack && bus.perr[1]) begin
                        state        <= S_CMP;
                        cmp_valid_r  <= 1'b1;
                        cmp_status_r <= CMP_BUS_ERR;
                    end else if (ack) begin
                        unique case (state)
                            S_LD_SRC: begin
                                state    <= S_LD_DST;
                                paddr_r  <= REG_WRITE_DEST;
                                pwdata_r <= cur_dst;
                                pwen_r   <= 1'b1;
                            end
                            S_LD_DST: begin
                                state    <= S_LD_LEN;
                                paddr_r  <= REG_BURST_SIZE;
                                pwdata_r <= {20'd0, cur_len};
                                pwen_r   <= 1'b1;
                            end
                            S_LD_LEN: begin
                                state    <= S_START;
                                paddr_r  <= REG_START;
                                pwdata_r <= 32'd1;
                                pwen_r   <= 1'b1;
                            end
                            S_START: begin
                                state   <= S_POLL;
                                paddr_r <= REG_WRITE_STATUS;
                                pren_r  <= 1'b1;
                            end
                            default: begin
                                unique case (1'b1)
                                    (poll_st == ST_DONE): begin
                                        state        <= S_CMP;
                                        cmp_valid_r  <= 1'b1;
                                        cmp_status_r <= CMP_OK;
                                    end
                                    (poll_st == ST_ERR): begin
                                        state        <= S_CMP;
                                        cmp_valid_r  <= 1'b1;
                                        cmp_status_r <= CMP_DMA_ERR;
                                    end
                                    default: begin
                                        state   <= S_GAP;
                                        gap_cnt <= GW'(POLL_GAP - 1);
                                    end
                                endcase
                            end
                        endcase
                    end else if (acc_expired) begin
                        state        <= S_CMP;
                        cmp_valid_r  <= 1'b1;
                        cmp_status_r <= CMP_TIMEOUT;
                    end
                end
            endcase
        end
    end

    assign bus.paddr    = paddr_r;
    assign bus.pwdata   = pwdata_r;
    assign bus.pwenable = pwen_r;
    assign bus.prenable = pren_r;
    assign cmp_valid    = cmp_valid_r;
    assign cmp_status   = cmp_status_r;
    assign busy         = (state != S_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Directed bench for dma_desc_sequencer with a small DMA
// register model answering two cycles after each enable.
module tb_dma_desc_sequencer;
    import dma_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int POLL_GAP    = 8;
    localparam int TIMEOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_src = '0;
    logic [31:0] desc_dst = '0;
    logic [11:0] desc_len = '0;
    logic        cmp_valid;
    logic [1:0]  cmp_status;
    logic        busy;
    logic [2:0]  fifo_level;

    dma_desc_sequencer_if bus ();

    dma_desc_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .POLL_GAP    (POLL_GAP),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_src   (desc_src),
        .desc_dst   (desc_dst),
        .desc_len   (desc_len),
        .bus        (bus),
        .cmp_valid  (cmp_valid),
        .cmp_status (cmp_status),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // DMA model controls (written by the stimulus only)
    logic        hold = 1'b0;
    logic        hang_start = 1'b0;
    logic        bad_en = 1'b0;
    logic [31:0] bad_addr = '0;
    logic [1:0]  final_st = ST_DONE;
    int          busy_limit = 0;

    // DMA model state
    int          poll_n = 0;
    logic        armed = 1'b0;
    logic [31:0] a_addr = '0;
    logic        a_rd = 1'b0;

    always @(posedge clk) begin
        bus.perr <= 2'b00;
        if (!rstn) begin
            armed      <= 1'b0;
            bus.prdata <= '0;
        end else if (armed) begin
            if (!hold && !(hang_start && a_addr == REG_START)) begin
                armed    <= 1'b0;
                bus.perr <= {bad_en && (a_addr == bad_addr), 1'b1};
                if (a_rd) begin
                    bus.prdata <= {30'd0,
                        (poll_n < busy_limit) ? 2'b01 : final_st};
                    poll_n <= poll_n + 1;
                end
            end
        end else if (bus.pwenable || bus.prenable) begin
            armed  <= 1'b1;
            a_addr <= bus.paddr;
            a_rd   <= bus.prenable;
        end
    end

    // Bus / completion monitor
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          rd_cyc [$];
    logic [1:0]  cmp_st [$];
    int          both_cnt = 0;
    int          cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.pwenable) begin
            wr_addr.push_back(bus.paddr);
            wr_data.push_back(bus.pwdata);
        end
        if (bus.prenable) begin
            rd_cyc.push_back(cyc);
        end
        if (bus.pwenable && bus.prenable) begin
            both_cnt <= both_cnt + 1;
        end
        if (cmp_valid) begin
            cmp_st.push_back(cmp_status);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cmp(int target, int budget, string tag);
        int k = 0;
        while (cmp_st.size() < target && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 64'(cmp_st.size()), 64'(target));
    endtask

    task automatic push(logic [31:0] s, logic [31:0] d, logic [11:0] l);
        int k = 0;
        desc_valid = 1'b1;
        desc_src   = s;
        desc_dst   = d;
        desc_len   = l;
        while (!desc_ready && k < 300) begin
            step(1);
            k++;
        end
        step(1);
        desc_valid = 1'b0;
        if (k >= 300) chk("push_ready", 64'(desc_ready), 64'd1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_ready"}, 64'(desc_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_level"}, 64'(fifo_level), 64'd0);
        chk({tag, "_cmpv"}, 64'(cmp_valid), 64'd0);
        chk({tag, "_cmps"}, 64'(cmp_status), 64'd0);
        chk({tag, "_pwen"}, 64'(bus.pwenable), 64'd0);
        chk({tag, "_pren"}, 64'(bus.prenable), 64'd0);
        chk({tag, "_paddr"}, 64'(bus.paddr), 64'd0);
        chk({tag, "_pwdata"}, 64'(bus.pwdata), 64'd0);
    endtask

    logic [31:0] t1_addr [4] = '{32'h00, 32'h04, 32'h08, 32'h0C};
    logic [31:0] t1_data [4] = '{32'h1000, 32'h2000, 32'd16, 32'd1};
    logic [31:0] t2_src [6] = '{32'hA000, 32'h100, 32'h200,
                                32'h300, 32'h400, 32'h500};

    initial begin
        int w0;
        int r0;
        int c0;
        int k;
        int ns;

        // reset
        rstn = 1'b0;
        step(3);
        chk_reset_outputs("rst");
        rstn = 1'b1;
        step(2);

        // 1: full transfer, three BUSY polls then DONE
        w0 = wr_addr.size();
        r0 = rd_cyc.size();
        c0 = cmp_st.size();
        busy_limit = poll_n + 3;
        push(32'h1000, 32'h2000, 12'd16);
        wait_cmp(c0 + 1, 400, "t1_cmp_cnt");
        chk("t1_wr_cnt", 64'(wr_addr.size() - w0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_addr", 64'(wr_addr[w0 + i]), 64'(t1_addr[i]));
            chk("t1_wr_data", 64'(wr_data[w0 + i]), 64'(t1_data[i]));
        end
        chk("t1_rd_cnt", 64'(rd_cyc.size() - r0), 64'd4);
        for (int i = 0; i < 3; i++) begin
            chk("t1_poll_gap", 64'(rd_cyc[r0 + i + 1] - rd_cyc[r0 + i]),
                64'(POLL_GAP + 3));
        end
        chk("t1_status", 64'(cmp_st[c0]), 64'd0);
        step(2);
        chk("t1_one_pulse", 64'(cmp_st.size()), 64'(c0 + 1));
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: sequencer stalled, FIFO fills to FIFO_DEPTH
        w0 = wr_addr.size();
        c0 = cmp_st.size();
        busy_limit = poll_n;
        hold = 1'b1;
        push(32'hA000, 32'hB000, 12'd4);
        step(2);
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_lvl0", 64'(fifo_level), 64'd0);
        for (int i = 0; i < 4; i++) begin
            push(32'(32'h100 * (i + 1)), 32'hC000, 12'd4);
            chk("t2_level", 64'(fifo_level), 64'(i + 1));
        end
        desc_valid = 1'b1;
        desc_src   = 32'h500;
        desc_dst   = 32'hC000;
        desc_len   = 12'd4;
        chk("t2_full_ready", 64'(desc_ready), 64'd0);
        step(3);
        chk("t2_full_ready_hold", 64'(desc_ready), 64'd0);
        chk("t2_full_level", 64'(fifo_level), 64'd4);
        hold = 1'b0;
        k = 0;
        while (!desc_ready && k < 300) begin
            step(1);
            k++;
        end
        chk("t2_accept", 64'(desc_ready), 64'd1);
        step(1);
        desc_valid = 1'b0;
        wait_cmp(c0 + 6, 2000, "t2_cmp_cnt");
        ns = 0;
        for (int i = w0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] == REG_READ_SOURCE) begin
                if (ns < 6) chk("t2_order", 64'(wr_data[i]), 64'(t2_src[ns]));
                ns++;
            end
        end
        chk("t2_src_cnt", 64'(ns), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_status", 64'(cmp_st[c0 + i]), 64'd0);
        end
        chk("t2_empty", 64'(fifo_level), 64'd0);

        // 3: zero-length descriptor
        w0 = wr_addr.size();
        r0 = rd_cyc.size();
        c0 = cmp_st.size();
        push(32'h3000, 32'h4000, 12'd0);
        chk("t3_queued", 64'(fifo_level), 64'd1);
        chk("t3_no_cmp_yet", 64'(cmp_valid), 64'd0);
        step(1);
        chk("t3_cmp_valid", 64'(cmp_valid), 64'd1);
        chk("t3_cmp_status", 64'(cmp_status), 64'd0);
        chk("t3_popped", 64'(fifo_level), 64'd0);
        step(1);
        chk("t3_cmp_drop", 64'(cmp_valid), 64'd0);
        chk("t3_wr_none", 64'(wr_addr.size() - w0), 64'd0);
        chk("t3_rd_none", 64'(rd_cyc.size() - r0), 64'd0);
        chk("t3_cmp_cnt", 64'(cmp_st.size()), 64'(c0 + 1));

        // 4: bus error on LD_DST, then a clean descriptor
        bad_en   = 1'b1;
        bad_addr = REG_WRITE_DEST;
        w0 = wr_addr.size();
        c0 = cmp_st.size();
        push(32'h5000, 32'h6000, 12'd32);
        wait_cmp(c0 + 1, 300, "t4_cmp_cnt");
        chk("t4_status", 64'(cmp_st[c0]), 64'd1);
        chk("t4_wr_cnt", 64'(wr_addr.size() - w0), 64'd2);
        chk("t4_last_addr", 64'(wr_addr[wr_addr.size() - 1]), 64'(REG_WRITE_DEST));
        bad_en = 1'b0;
        step(2);
        w0 = wr_addr.size();
        push(32'h5100, 32'h6100, 12'd8);
        wait_cmp(c0 + 2, 300, "t4_next_cnt");
        chk("t4_next_status", 64'(cmp_st[c0 + 1]), 64'd0);
        chk("t4_next_wr_cnt", 64'(wr_addr.size() - w0), 64'd4);

        // 5a: DMA reports error after one BUSY poll
        final_st = ST_ERR;
        busy_limit = poll_n + 1;
        c0 = cmp_st.size();
        push(32'h6000, 32'h7000, 12'd2);
        wait_cmp(c0 + 1, 300, "t5_cmp_cnt");
        chk("t5_status", 64'(cmp_st[c0]), 64'd2);
        final_st = ST_DONE;
        step(2);

        // 5b: reset while waiting in GAP, one more descriptor queued
        busy_limit = poll_n + 100;
        r0 = rd_cyc.size();
        c0 = cmp_st.size();
        w0 = wr_addr.size();
        push(32'h7000, 32'h8000, 12'd4);
        k = 0;
        while (rd_cyc.size() == r0 && k < 200) begin
            step(1);
            k++;
        end
        chk("t5_polled", 64'(rd_cyc.size() - r0), 64'd1);
        step(4);
        push(32'h7100, 32'h8100, 12'd4);
        chk("t5_pre_level", 64'(fifo_level), 64'd1);
        chk("t5_pre_busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        step(1);
        chk_reset_outputs("t5_rst");
        rstn = 1'b1;
        step(20);
        chk("t5_no_cmp", 64'(cmp_st.size()), 64'(c0));
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_no_wr", 64'(wr_addr.size() - w0), 64'd4);
        busy_limit = poll_n;

        // 6: START write never completes
        hang_start = 1'b1;
        c0 = cmp_st.size();
        w0 = wr_addr.size();
        push(32'h8000, 32'h9000, 12'd4);
`ifdef DESC_SEQ_TIMEOUT_EN
        wait_cmp(c0 + 1, TIMEOUT_CYC + 100, "t6_cmp_cnt");
        chk("t6_status", 64'(cmp_st[c0]), 64'd3);
        step(2);
        chk("t6_idle", 64'(busy), 64'd0);
`else
        step(300);
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_no_cmp", 64'(cmp_st.size()), 64'(c0));
`endif
        chk("t6_wr_cnt", 64'(wr_addr.size() - w0), 64'd4);
        chk("t6_one_enable", 64'(both_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
